// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: control bundle widths, control field positions,
// and debug readback select encodings.
package pipeline_pkg;

    // Default control bundle widths
    localparam int CEX_W_DEF = 4;
    localparam int CM_W_DEF  = 5;
    localparam int CWB_W_DEF = 6;

    // EX bundle field positions
    localparam int EX_ALUSRC    = 0;
    localparam int EX_ALUOP_LSB = 1;
    localparam int EX_ALUOP_MSB = 2;
    localparam int EX_REGDST    = 3;

    // M bundle field positions
    localparam int M_BRANCH   = 0;
    localparam int M_MEMWRITE = 1;
    localparam int M_MEMREAD  = 2;
    localparam int M_TAM_LSB  = 3;
    localparam int M_TAM_MSB  = 4;

    // WB bundle field positions
    localparam int WB_MEMTOREG = 0;
    localparam int WB_REGWRITE = 1;
    localparam int WB_TAML_LSB = 2;
    localparam int WB_TAML_MSB = 3;
    localparam int WB_ZEROEXT  = 4;
    localparam int WB_LUI      = 5;

    // Debug readback select encodings
    typedef enum logic [2:0] {
        DBG_PC4   = 3'd0,
        DBG_INSTR = 3'd1,
        DBG_REG1  = 3'd2,
        DBG_REG2  = 3'd3,
        DBG_EXT   = 3'd4,
        DBG_IDX   = 3'd5,
        DBG_CTRL  = 3'd6,
        DBG_BUBL  = 3'd7
    } dbg_sel_e;

endpackage

// File: rtl/etapa_sat_counter.sv
// Saturating up-counter with synchronous clear; updates on the falling clock edge.
module etapa_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Next count: clear wins, otherwise increment until all-ones and stick there
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register, falling-edge to match the rest of the ID/EX stage
    always_ff @(negedge i_clk) begin
        cnt_q <= cnt_d;
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/etapa_id_ex_gen.sv
// ID/EX pipeline register with run/step gating, stall hold, flush bubbles,
// valid tracking, a bubble counter and a debug readback mux.
module etapa_id_ex_gen
    import pipeline_pkg::*;
#(
    parameter int NBITS  = 32,
    parameter int RNBITS = 5,
    parameter int CEX_W  = CEX_W_DEF,
    parameter int CM_W   = CM_W_DEF,
    parameter int CWB_W  = CWB_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic              i_valid,
    input  logic [NBITS-1:0]  i_PC4,
    input  logic [NBITS-1:0]  i_Instruction,
    input  logic [NBITS-1:0]  i_Registro1,
    input  logic [NBITS-1:0]  i_Registro2,
    input  logic [NBITS-1:0]  i_Extension,
    input  logic [RNBITS-1:0] i_Rs,
    input  logic [RNBITS-1:0] i_Rt,
    input  logic [RNBITS-1:0] i_Rd,
    input  logic [CEX_W-1:0]  i_CtrlEX,
    input  logic [CM_W-1:0]   i_CtrlM,
    input  logic [CWB_W-1:0]  i_CtrlWB,
    input  logic [2:0]        i_dbg_sel,
    output logic              o_valid,
    output logic [NBITS-1:0]  o_PC4,
    output logic [NBITS-1:0]  o_Instruction,
    output logic [NBITS-1:0]  o_Registro1,
    output logic [NBITS-1:0]  o_Registro2,
    output logic [NBITS-1:0]  o_Extension,
    output logic [RNBITS-1:0] o_Rs,
    output logic [RNBITS-1:0] o_Rt,
    output logic [RNBITS-1:0] o_Rd,
    output logic [CEX_W-1:0]  o_CtrlEX,
    output logic [CM_W-1:0]   o_CtrlM,
    output logic [CWB_W-1:0]  o_CtrlWB,
    output logic [CNT_W-1:0]  o_bubble_cnt,
    output logic [NBITS-1:0]  o_dbg_data
);

    logic              valid_d, valid_q;
    logic [NBITS-1:0]  pc4_d, pc4_q, instr_d, instr_q;
    logic [NBITS-1:0]  reg1_d, reg1_q, reg2_d, reg2_q, ext_d, ext_q;
    logic [RNBITS-1:0] rs_d, rs_q, rt_d, rt_q, rd_d, rd_q;
    logic [CEX_W-1:0]  cex_d, cex_q;
    logic [CM_W-1:0]   cm_d, cm_q;
    logic [CWB_W-1:0]  cwb_d, cwb_q;
    logic              bubble_inc_s;
    logic [CNT_W-1:0]  bubble_cnt_s;
    logic [NBITS-1:0]  dbg_data_s;

    // Next-state: reset > freeze > flush > stall > load
    always_comb begin
        valid_d = valid_q;
        pc4_d   = pc4_q;
        instr_d = instr_q;
        reg1_d  = reg1_q;
        reg2_d  = reg2_q;
        ext_d   = ext_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        cex_d   = cex_q;
        cm_d    = cm_q;
        cwb_d   = cwb_q;
        if (i_reset) begin
            valid_d = 1'b0;
            pc4_d   = '0;
            instr_d = '0;
            reg1_d  = '0;
            reg2_d  = '0;
            ext_d   = '0;
            rs_d    = '0;
            rt_d    = '0;
            rd_d    = '0;
            cex_d   = '0;
            cm_d    = '0;
            cwb_d   = '0;
        end else if (!i_enable) begin
            // Debug unit has the stage frozen: everything holds
            valid_d = valid_q;
        end else if (i_flush) begin
            // Bubble: kill the slot and its side effects, keep the payload
            valid_d = 1'b0;
            cex_d   = '0;
            cm_d    = '0;
            cwb_d   = '0;
        end else if (i_stall) begin
            valid_d = valid_q;
        end else begin
            valid_d = i_valid;
            pc4_d   = i_PC4;
            instr_d = i_Instruction;
            reg1_d  = i_Registro1;
            reg2_d  = i_Registro2;
            ext_d   = i_Extension;
            rs_d    = i_Rs;
            rt_d    = i_Rt;
            rd_d    = i_Rd;
            // An invalid slot never carries live control
            cex_d   = i_valid ? i_CtrlEX : '0;
            cm_d    = i_valid ? i_CtrlM  : '0;
            cwb_d   = i_valid ? i_CtrlWB : '0;
        end
    end

    // Stage registers, updated on the falling edge
    always_ff @(negedge i_clk) begin
        valid_q <= valid_d;
        pc4_q   <= pc4_d;
        instr_q <= instr_d;
        reg1_q  <= reg1_d;
        reg2_q  <= reg2_d;
        ext_q   <= ext_d;
        rs_q    <= rs_d;
        rt_q    <= rt_d;
        rd_q    <= rd_d;
        cex_q   <= cex_d;
        cm_q    <= cm_d;
        cwb_q   <= cwb_d;
    end

    // A bubble is counted only when the flush actually takes effect
    assign bubble_inc_s = !i_reset && i_enable && i_flush;

    etapa_sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .i_clk (i_clk),
        .i_clr (i_reset),
        .i_inc (bubble_inc_s),
        .o_cnt (bubble_cnt_s)
    );

    // Debug readback of registered state, zero-extended or truncated to NBITS
    always_comb begin
        dbg_data_s = '0;
        case (dbg_sel_e'(i_dbg_sel))
            DBG_PC4:   dbg_data_s = pc4_q;
            DBG_INSTR: dbg_data_s = instr_q;
            DBG_REG1:  dbg_data_s = reg1_q;
            DBG_REG2:  dbg_data_s = reg2_q;
            DBG_EXT:   dbg_data_s = ext_q;
            DBG_IDX:   dbg_data_s = NBITS'({rs_q, rt_q, rd_q});
            DBG_CTRL:  dbg_data_s = NBITS'({valid_q, cwb_q, cm_q, cex_q});
            DBG_BUBL:  dbg_data_s = NBITS'(bubble_cnt_s);
            default:   dbg_data_s = '0;
        endcase
    end

    assign o_valid       = valid_q;
    assign o_PC4         = pc4_q;
    assign o_Instruction = instr_q;
    assign o_Registro1   = reg1_q;
    assign o_Registro2   = reg2_q;
    assign o_Extension   = ext_q;
    assign o_Rs          = rs_q;
    assign o_Rt          = rt_q;
    assign o_Rd          = rd_q;
    assign o_CtrlEX      = cex_q;
    assign o_CtrlM       = cm_q;
    assign o_CtrlWB      = cwb_q;
    assign o_bubble_cnt  = bubble_cnt_s;
    assign o_dbg_data    = dbg_data_s;

endmodule

// File: tb/tb_etapa_id_ex_gen.sv
// Bench for etapa_id_ex_gen: behavioural model + per-cycle compare, plus
// hand-computed literal checks. A second instance with CNT_W=2 covers saturation.
module tb_etapa_id_ex_gen;

    logic        clk = 1'b1;
    logic        reset, enable, stall, flush, valid;
    logic [31:0] pc4, instr, r1, r2, ext;
    logic [4:0]  rs, rt, rd;
    logic [3:0]  cex;
    logic [4:0]  cm;
    logic [5:0]  cwb;
    logic [2:0]  dbg_sel;

    logic        a_valid, b_valid;
    logic [31:0] a_pc4, a_ins, a_r1, a_r2, a_ext, a_dbg;
    logic [31:0] b_pc4, b_ins, b_r1, b_r2, b_ext, b_dbg;
    logic [4:0]  a_rs, a_rt, a_rd, b_rs, b_rt, b_rd;
    logic [3:0]  a_cex, b_cex;
    logic [4:0]  a_cm, b_cm;
    logic [5:0]  a_cwb, b_cwb;
    logic [15:0] a_cnt;
    logic [1:0]  b_cnt;

    int checks = 0;
    int errors = 0;

    // Model state
    bit          armed = 1'b0;
    bit          m_valid;
    logic [31:0] m_pc4, m_ins, m_r1, m_r2, m_ext;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic [3:0]  m_cex;
    logic [4:0]  m_cm;
    logic [5:0]  m_cwb;
    int          m_cnt, m_cnt2;

    always #5 clk = ~clk;

    etapa_id_ex_gen #(.CNT_W(16)) dut (
        .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_stall(stall),
        .i_flush(flush), .i_valid(valid), .i_PC4(pc4), .i_Instruction(instr),
        .i_Registro1(r1), .i_Registro2(r2), .i_Extension(ext),
        .i_Rs(rs), .i_Rt(rt), .i_Rd(rd), .i_CtrlEX(cex), .i_CtrlM(cm),
        .i_CtrlWB(cwb), .i_dbg_sel(dbg_sel), .o_valid(a_valid), .o_PC4(a_pc4),
        .o_Instruction(a_ins), .o_Registro1(a_r1), .o_Registro2(a_r2),
        .o_Extension(a_ext), .o_Rs(a_rs), .o_Rt(a_rt), .o_Rd(a_rd),
        .o_CtrlEX(a_cex), .o_CtrlM(a_cm), .o_CtrlWB(a_cwb),
        .o_bubble_cnt(a_cnt), .o_dbg_data(a_dbg)
    );

    etapa_id_ex_gen #(.CNT_W(2)) dut2 (
        .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_stall(stall),
        .i_flush(flush), .i_valid(valid), .i_PC4(pc4), .i_Instruction(instr),
        .i_Registro1(r1), .i_Registro2(r2), .i_Extension(ext),
        .i_Rs(rs), .i_Rt(rt), .i_Rd(rd), .i_CtrlEX(cex), .i_CtrlM(cm),
        .i_CtrlWB(cwb), .i_dbg_sel(dbg_sel), .o_valid(b_valid), .o_PC4(b_pc4),
        .o_Instruction(b_ins), .o_Registro1(b_r1), .o_Registro2(b_r2),
        .o_Extension(b_ext), .o_Rs(b_rs), .o_Rt(b_rt), .o_Rd(b_rd),
        .o_CtrlEX(b_cex), .o_CtrlM(b_cm), .o_CtrlWB(b_cwb),
        .o_bubble_cnt(b_cnt), .o_dbg_data(b_dbg)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected debug word from model state, by plain arithmetic
    function automatic logic [31:0] dbg_exp(input logic [2:0] sel, input int cnt);
        case (sel)
            3'd0: return m_pc4;
            3'd1: return m_ins;
            3'd2: return m_r1;
            3'd3: return m_r2;
            3'd4: return m_ext;
            3'd5: return 32'(m_rs) * 32'd1024 + 32'(m_rt) * 32'd32 + 32'(m_rd);
            3'd6: return (m_valid ? 32'd32768 : 32'd0) + 32'(m_cwb) * 32'd512
                         + 32'(m_cm) * 32'd16 + 32'(m_cex);
            default: return 32'(cnt);
        endcase
    endfunction

    // Model: apply the stage rules at every falling edge
    always @(negedge clk) begin
        if (reset) begin
            m_valid = 1'b0; m_pc4 = 0; m_ins = 0; m_r1 = 0; m_r2 = 0; m_ext = 0;
            m_rs = 0; m_rt = 0; m_rd = 0; m_cex = 0; m_cm = 0; m_cwb = 0;
            m_cnt = 0; m_cnt2 = 0;
        end else if (enable && flush) begin
            m_valid = 1'b0; m_cex = 0; m_cm = 0; m_cwb = 0;
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            if (m_cnt2 < 3) m_cnt2 = m_cnt2 + 1;
        end else if (enable && !stall) begin
            m_valid = valid; m_pc4 = pc4; m_ins = instr; m_r1 = r1; m_r2 = r2;
            m_ext = ext; m_rs = rs; m_rt = rt; m_rd = rd;
            m_cex = valid ? cex : 4'd0;
            m_cm  = valid ? cm  : 5'd0;
            m_cwb = valid ? cwb : 6'd0;
        end
        armed = 1'b1;
    end

    // Compare both instances against the model shortly after each falling edge
    always @(negedge clk) begin
        #2;
        if (armed) begin
            chk("valid", a_valid, m_valid);     chk("valid2", b_valid, m_valid);
            chk("pc4", a_pc4, m_pc4);           chk("pc4_2", b_pc4, m_pc4);
            chk("instr", a_ins, m_ins);         chk("instr2", b_ins, m_ins);
            chk("reg1", a_r1, m_r1);            chk("reg1_2", b_r1, m_r1);
            chk("reg2", a_r2, m_r2);            chk("reg2_2", b_r2, m_r2);
            chk("ext", a_ext, m_ext);           chk("ext2", b_ext, m_ext);
            chk("rs", a_rs, m_rs);              chk("rs2", b_rs, m_rs);
            chk("rt", a_rt, m_rt);              chk("rt2", b_rt, m_rt);
            chk("rd", a_rd, m_rd);              chk("rd2", b_rd, m_rd);
            chk("cex", a_cex, m_cex);           chk("cex2", b_cex, m_cex);
            chk("cm", a_cm, m_cm);              chk("cm2", b_cm, m_cm);
            chk("cwb", a_cwb, m_cwb);           chk("cwb2", b_cwb, m_cwb);
            chk("bubble_cnt", a_cnt, m_cnt);    chk("bubble_cnt2", b_cnt, m_cnt2);
            chk("dbg", a_dbg, dbg_exp(dbg_sel, m_cnt));
            chk("dbg2", b_dbg, dbg_exp(dbg_sel, m_cnt2));
            if (!m_valid) chk("invalid_ctrl_zero", {a_cex, a_cm, a_cwb}, 64'd0);
        end
    end

    // One falling edge, then a little settle time before checking/driving
    task automatic step();
        @(negedge clk);
        #3;
    endtask

    initial begin
        // Reset with every input driven to all-ones
        reset = 1'b1; enable = 1'b1; stall = 1'b1; flush = 1'b1; valid = 1'b1;
        pc4 = '1; instr = '1; r1 = '1; r2 = '1; ext = '1;
        rs = '1; rt = '1; rd = '1; cex = '1; cm = '1; cwb = '1; dbg_sel = 3'd5;
        step();
        chk("lit_reset_pc4", a_pc4, 64'd0);
        chk("lit_reset_valid", a_valid, 64'd0);
        chk("lit_reset_cnt", a_cnt, 64'd0);
        chk("lit_reset_ctrl", {a_cex, a_cm, a_cwb}, 64'd0);

        // Load a lw
        reset = 1'b0; stall = 1'b0; flush = 1'b0; valid = 1'b1;
        pc4 = 32'h0000_0010; instr = 32'h8C22_0004;
        r1 = 32'h0000_1111; r2 = 32'h0000_2222; ext = 32'h0000_0004;
        rs = 5'd1; rt = 5'd2; rd = 5'd3;
        cex = 4'b0011; cm = 5'b00100; cwb = 6'b000011;
        step();
        chk("lit_load_pc4", a_pc4, 64'h10);
        chk("lit_load_instr", a_ins, 64'h8C22_0004);
        chk("lit_load_cwb", a_cwb, 64'h3);
        chk("lit_load_valid", a_valid, 64'd1);
        chk("lit_dbg_idx", a_dbg, 64'h443);

        // Stall for three edges while the inputs move on
        stall = 1'b1; pc4 = 32'h0000_0014; instr = 32'h0000_0000; rd = 5'd9;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("lit_stall_pc4", a_pc4, 64'h10);
            chk("lit_stall_instr", a_ins, 64'h8C22_0004);
        end
        stall = 1'b0;
        step();
        chk("lit_release_pc4", a_pc4, 64'h14);

        // Flush together with stall, four times in a row
        flush = 1'b1; stall = 1'b1; pc4 = 32'h0000_0018; dbg_sel = 3'd7;
        step();
        chk("lit_flush_valid", a_valid, 64'd0);
        chk("lit_flush_ctrl", {a_cex, a_cm, a_cwb}, 64'd0);
        chk("lit_flush_pc4", a_pc4, 64'h14);
        chk("lit_flush_cnt", a_cnt, 64'd1);
        chk("lit_sat_1", b_cnt, 64'd1);
        step(); chk("lit_sat_2", b_cnt, 64'd2);
        step(); chk("lit_sat_3", b_cnt, 64'd3);
        step(); chk("lit_sat_4", b_cnt, 64'd3);
        chk("lit_cnt_4", a_cnt, 64'd4);
        chk("lit_dbg_cnt", a_dbg, 64'd4);

        // Frozen stage ignores flush and load
        enable = 1'b0; stall = 1'b0;
        step();
        chk("lit_freeze_cnt", a_cnt, 64'd4);
        flush = 1'b0; valid = 1'b1; pc4 = 32'h0000_0100;
        step();
        chk("lit_freeze_pc4", a_pc4, 64'h14);

        // Invalid slot loads with control forced to zero
        enable = 1'b1; valid = 1'b0; cex = '1; cm = '1; cwb = '1; dbg_sel = 3'd6;
        step();
        chk("lit_invalid_cwb", a_cwb, 64'd0);
        chk("lit_invalid_pc4", a_pc4, 64'h100);

        // Valid loads while sweeping the debug select
        valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            dbg_sel = 3'(i);
            pc4 = 32'h1000 + 32'(i) * 32'd4; instr = 32'hA5A5_0000 + 32'(i);
            r1 = 32'hDEAD_0000 + 32'(i); r2 = ~r1; ext = 32'hFFFF_FFF0 + 32'(i);
            rs = 5'(i + 7); rt = 5'(31 - i); rd = 5'(i * 3);
            cex = 4'(i); cm = 5'(i * 2 + 1); cwb = 6'(i * 5);
            step();
        end

        // Reset wins even while frozen
        enable = 1'b0; reset = 1'b1;
        step();
        chk("lit_reset_frozen_cnt", a_cnt, 64'd0);
        chk("lit_reset_frozen_pc4", a_pc4, 64'd0);
        reset = 1'b0; enable = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net so the run always terminates
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1);
    end

endmodule

// File: doc/etapa_id_ex_gen.md
Name: etapa_id_ex_gen

Overview:
Parametrised ID/EX pipeline register for the MIPS core. It adds the following over a plain latch stage:
- synchronous reset
- debug-unit run/step gating
- hazard-unit stall (hold)
- flush with bubble insertion
- valid bit
- saturating bubble counter
- debug readback mux

It sits between decode (register file, sign extender, control unit) and execute (ALU, forwarding unit).

Parameters:
- NBITS, 32, datapath word width (PC4, instruction, operands, extension).
- RNBITS, 5, register-index width (Rs, Rt, Rd).
- CEX_W, 4, EX control bundle width (ALUSrc, ALUOp[1:0], RegDst).
- CM_W, 5, M control bundle width (Branch, MemWrite, MemRead, TamanoFiltro[1:0]).
- CWB_W, 6, WB control bundle width (MemToReg, RegWrite, TamanoFiltroL[1:0], ZeroExtend, LUI).
- CNT_W, 16, bubble counter width.

Ports:
- i_clk in 1: clock; all state updates on the falling edge.
- i_reset in 1: synchronous, active-high reset, sampled on the falling edge of i_clk.
- i_enable in 1: debug-unit run/step gate; 0 = freeze the whole stage.
- i_stall in 1: hazard unit hold request.
- i_flush in 1: hazard/branch unit bubble request.
- i_valid in 1: upstream slot holds a real instruction.
- i_PC4, i_Instruction, i_Registro1, i_Registro2, i_Extension in NBITS each: decode payload.
- i_Rs, i_Rt, i_Rd in RNBITS each: register indices (Rs is new, for forwarding).
- i_CtrlEX in CEX_W, i_CtrlM in CM_W, i_CtrlWB in CWB_W: control bundles.
- i_dbg_sel in 3: debug readback select.
- o_valid out 1: registered valid.
- o_PC4, o_Instruction, o_Registro1, o_Registro2, o_Extension out NBITS each: registered payload.
- o_Rs, o_Rt, o_Rd out RNBITS each: registered indices.
- o_CtrlEX, o_CtrlM, o_CtrlWB out: registered control bundles.
- o_bubble_cnt out CNT_W: number of bubbles inserted.
- o_dbg_data out NBITS: debug readback word.

Behaviour:
- All registers update only on the falling edge of i_clk; latency is 1 edge from input to output.
- Priority, evaluated at each falling edge:
  1. i_reset
  2. !i_enable
  3. i_flush
  4. i_stall
  5. load
- Reset: every output register is cleared to 0: payload, indices, control bundles, o_valid and o_bubble_cnt. Reset overrides i_enable; asserting it mid-stall or mid-flush clears everything on that edge.
- !i_enable: all registers hold. Flush and stall are ignored and the counter does not change.
- Flush: o_valid <= 0 and o_CtrlEX, o_CtrlM, o_CtrlWB <= 0, so no RegWrite, MemWrite or Branch reaches later stages. Payload and index registers hold their values. o_bubble_cnt increments by 1, saturating at all-ones. Flush wins over a simultaneous stall.
- Stall without flush: all registers hold, including o_valid; the counter does not change.
- Load: all registers <= inputs and o_valid <= i_valid. When i_valid=0, control bundles are loaded as 0 regardless of their inputs, which enforces the invariant: o_valid=0 implies all control outputs are 0.
- Bubble counter: increments only on flush edges, never wraps, and is cleared only by reset.
- o_dbg_data is a combinational mux of the registered state, zero-extended to NBITS:
  - 0: PC4
  - 1: Instruction
  - 2: Registro1
  - 3: Registro2
  - 4: Extension
  - 5: {Rs, Rt, Rd} in the LSBs
  - 6: {o_valid, CtrlWB, CtrlM, CtrlEX} in the LSBs
  - 7: bubble count
- Packed fields wider than NBITS are truncated to the LSBs.

Decomposition:
- Shared package (pipeline_pkg):
  - the CEX_W, CM_W and CWB_W defaults
  - the bit positions of each control field inside the bundles (ALUSrc = EX[0], ALUOp = EX[2:1], RegDst = EX[3], etc.)
  - the DBG_SEL encodings 0..7
- One natural sub-module, etapa_sat_counter: a CNT_W saturating counter with synchronous clear and increment enable. The flush/stall/load register logic stays in the top level.

Test Plan:
- Reset: pulse i_reset with all inputs = 0xFFFFFFFF and i_enable=1 -> after the edge, all outputs 0, o_valid=0, o_bubble_cnt=0.
- Load: i_PC4=0x00000010, i_Instruction=0x8C220004 (lw), i_CtrlWB=6'b000011, i_valid=1 -> next edge: outputs match inputs, o_valid=1.
- Stall: hold i_stall=1 for 3 edges while inputs change to 0x00000014 -> outputs remain 0x00000010 / 0x8C220004 for all 3 edges; load resumes on the edge after release.
- Flush: i_flush=1 and i_stall=1 together -> o_valid=0, all Ctrl outputs 0, o_PC4 unchanged, o_bubble_cnt 0->1.
- Counter saturation: CNT_W=2, four consecutive flushes -> o_bubble_cnt sequence 1, 2, 3, 3.
- Debug gate: i_enable=0 with i_flush=1 -> no state change, counter unchanged. i_dbg_sel=5 with Rs=1, Rt=2, Rd=3 -> o_dbg_data=0x00000443. i_reset=1 while i_enable=0 -> cleared.
